// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with internal pointers, occupancy count, threshold flags
// and sticky overflow/underflow flags. The read port is registered.
module fifo_param #(
    parameter int DATA_WIDTH = 10,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ADDR_WIDTH:0]   almost_full_th,
    input  logic [ADDR_WIDTH:0]   almost_empty_th,
    input  logic                  err_clr,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   DEPTH_C = DEPTH;
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = 1;
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  valid_q, valid_d, ovf_q, ovf_d, udf_q, udf_d;
    logic                  pop_acc, push_acc;

    // Flags depend only on the count register, never on push/pop.
    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= almost_full_th);
    assign almost_empty = (count_q <= almost_empty_th);

    // A pop frees a slot in the same cycle, so a full FIFO still takes a push alongside it.
    assign pop_acc  = pop && !empty;
    assign push_acc = push && (!full || pop_acc);

    always_comb begin
        wr_ptr_d = push_acc ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop_acc  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d  = count_q;
        if (push_acc && !pop_acc)      count_d = count_q + CNT_ONE;
        else if (pop_acc && !push_acc) count_d = count_q - CNT_ONE;
        dout_d  = pop_acc ? mem_q[rd_ptr_q] : dout_q;
        valid_d = pop_acc;
        // A new error outranks a clear in the same cycle.
        ovf_d = (push && !push_acc) ? 1'b1 : (err_clr ? 1'b0 : ovf_q);
        udf_d = (pop && !pop_acc)   ? 1'b1 : (err_clr ? 1'b0 : udf_q);
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (push_acc) mem_q[wr_ptr_q] <= data_in;
    end

    assign data_out  = dout_q;
    assign valid     = valid_q;
    assign count     = count_q;
    assign overflow  = ovf_q;
    assign underflow = udf_q;
endmodule

// File: doc/fifo_param.md
Name: fifo_param

Overview:
- Parametrised synchronous FIFO. Successor to the fixed 8x10 memory block, whose write and read pointers are driven externally.
- Pointers, occupancy count, full/empty flags, programmable almost-full/almost-empty thresholds and sticky error flags are all generated internally.
- Sits in the transaction layer between the input demux and the per-lane output logic.
- Storage is a register array of 2**ADDR_WIDTH words; the read port is registered.

Parameters:
DATA_WIDTH, 10, word width in bits
ADDR_WIDTH, 3, pointer width; DEPTH = 2**ADDR_WIDTH entries (default 8)

Ports:
clk  input  1  rising-edge clock
reset_L  input  1  asynchronous active-low reset
push  input  1  write request, sampled at posedge clk
pop  input  1  read request, sampled at posedge clk
data_in  input  DATA_WIDTH  write data, captured with an accepted push
almost_full_th  input  ADDR_WIDTH+1  almost-full threshold
almost_empty_th  input  ADDR_WIDTH+1  almost-empty threshold
err_clr  input  1  synchronous clear of the sticky error flags
data_out  output  DATA_WIDTH  registered read data
valid  output  1  data_out carries a newly popped word
count  output  ADDR_WIDTH+1  occupancy, 0..DEPTH
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= almost_full_th
almost_empty  output  1  count <= almost_empty_th
overflow  output  1  sticky: push rejected
underflow  output  1  sticky: pop rejected

Behaviour:
- Reset (reset_L low, asynchronous, independent of clk):
  - wr_ptr = rd_ptr = 0, count = 0, data_out = 0, valid = 0, overflow = underflow = 0.
  - Consequently empty = 1 and full = 0.
  - Storage contents are not cleared.
  - Reset asserted mid-operation discards all stored words immediately.
- Pointers: wr_ptr and rd_ptr are ADDR_WIDTH bits wide and wrap modulo DEPTH (7 -> 0 at the default size). There is no extra wrap bit; full and empty come from count.
- Push accepted when push && (!full || pop_accepted):
  - mem[wr_ptr] <= data_in.
  - wr_ptr increments.
- Pop accepted when pop && !empty:
  - data_out <= mem[rd_ptr].
  - rd_ptr increments.
  - valid <= 1 on the next clock edge.
- valid:
  - valid = 0 on any cycle without an accepted pop.
  - data_out holds its last value when no pop is accepted.
  - Read latency: data is on data_out one cycle after the pop edge.
- count next value:
  - +1 for push only.
  - -1 for pop only.
  - Unchanged for both or neither.
- Simultaneous push and pop:
  - When full: both are accepted, count stays DEPTH, no overflow.
  - When empty: the pop is rejected (underflow = 1), the push is accepted, count becomes 1.
  - When neither full nor empty: both are accepted, count is unchanged.
- Errors:
  - Rejected push sets overflow; rejected pop sets underflow.
  - Both flags hold until reset or err_clr = 1 at a clock edge.
  - A new error in the same cycle as err_clr takes priority, so the flag stays 1.
- Flags:
  - full, empty, almost_full and almost_empty are combinational from the count register only. They update in the cycle after the edge that changes count, with no combinational path from push or pop.
  - Thresholds are compared unsigned and may change at any time.
  - almost_full_th = 0 forces almost_full = 1.
  - almost_empty_th >= DEPTH forces almost_empty = 1.
- Written data is readable only after the write edge. No bypass: push to an empty FIFO plus pop in the same cycle does not return data_in.

Test Plan:
1. Reset: hold reset_L = 0 for 2 cycles -> count = 0, empty = 1, full = 0, valid = 0, data_out = 0, overflow = underflow = 0. Then drop reset_L asynchronously between clock edges while the FIFO holds 3 words -> count = 0 and empty = 1 immediately, without waiting for a clock edge.
2. Fill and wrap: push 0x0FF, 0x011, 0x022, 0x033, 0x044, 0x055, 0x066, 0x077 -> full = 1, count = 8.
   - Next, push 0x088 -> overflow = 1, count stays 8.
   - Then pop 8 times -> valid = 1 each cycle after a pop, data_out sequence 0x0FF..0x077, then empty = 1.
   - Repeat the fill and drain once more to cover pointer wrap.
3. Simultaneous push/pop:
   - At count = 8, push 0x099 with pop -> data_out = 0x0FF, count stays 8, no overflow.
   - At count = 0, push 0x0AA with pop -> underflow = 1, valid = 0, count = 1; the next pop returns 0x0AA.
4. Thresholds: almost_full_th = 6, almost_empty_th = 2.
   - Push 6 words -> almost_empty deasserts at count = 3, almost_full asserts at count = 6.
   - Change almost_full_th to 7 -> almost_full deasserts with no clock edge needed.
5. Error clear:
   - Pop while empty -> underflow = 1.
   - err_clr = 1 for one cycle -> underflow = 0.
   - err_clr together with a rejected pop -> underflow remains 1.
6. Parameter sweep: DATA_WIDTH = 16, ADDR_WIDTH = 4 -> full at count = 16, 16-bit data integrity across a wrap with alternating push/pop patterns. Results are compared cycle by cycle against the synthesised netlist output.
